// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 32-bit timer with prescaler, compare match and level IRQ.
//
// Ports:
//   clk_i      - single clock, rising edge
//   reset_i    - asynchronous active-high reset
//   address_i  - bus address, nonzero only on the first cycle of an access
//   data_i     - CPU write data
//   we_i       - one-cycle write pulse
//   we_ram_i   - byte-lane write strobes (bit n -> data_i[8n+7:8n])
//   data_o     - registered read data, 0 when this block is not addressed
//   irq_o      - registered MATCH & IRQEN
//
// Register map (word offsets from BaseAddress):
//   0 CTRL {IRQEN, AUTORELOAD, EN}   1 PRESCALE[15:0]   2 COMPARE
//   3 COUNT                          4 STATUS {MATCH}, W1C
//   5 CAPTURE (only with BUS_TIMER_CAPTURE_EN, otherwise reads 0)
//   6-7 read 0
//
// Optional feature macro: BUS_TIMER_CAPTURE_EN. When defined, any write to
// offset 5 snapshots the pre-update COUNT into CAPTURE.
module bus_timer #(
    parameter logic [31:0] BaseAddress   = 32'h0000_9000,
    parameter int unsigned address_width = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] address_i,
    input  logic [31:0]              data_i,
    input  logic                     we_i,
    input  logic [3:0]               we_ram_i,
    output logic [31:0]              data_o,
    output logic                     irq_o
);

    localparam logic [address_width-1:0] BASE = address_width'(BaseAddress);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COMPARE  = 3'd2;
    localparam logic [2:0] OFF_COUNT    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;
    localparam logic [2:0] OFF_CAPTURE  = 3'd5;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] count_q, count_d;
    logic        match_q, match_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [31:0] data_q, data_d;
    logic        irq_q, irq_d;
`ifdef BUS_TIMER_CAPTURE_EN
    logic [31:0] capture_q, capture_d;
`endif

    logic        sel_c;
    logic [2:0]  off_c;
    logic        wr_c;
    logic        tick_c;
    logic        hit_c;
    logic [31:0] rdata_c;
    logic [31:0] wmerge_c;
    logic        unused_addr_bits;

    assign sel_c  = (address_i[address_width-1:5] == BASE[address_width-1:5]);
    assign off_c  = address_i[4:2];
    assign wr_c   = sel_c & we_i;
    assign unused_addr_bits = ^address_i[1:0];

    // Tick when the prescale phase has reached PRESCALE; ">=" also covers a
    // PRESCALE written below the running phase (one tick, then wrap).
    assign tick_c = ctrl_q[0] && (pcnt_q >= prescale_q);
    assign hit_c  = tick_c && (count_q == compare_q);

    // Byte-lane merge of write data over the addressed register's current value.
    always_comb begin
        wmerge_c = '0;
        case (off_c)
            OFF_PRESCALE: wmerge_c = {16'd0, prescale_q};
            OFF_COMPARE:  wmerge_c = compare_q;
            OFF_COUNT:    wmerge_c = count_q;
            default:      wmerge_c = '0;
        endcase
        for (int n = 0; n < 4; n++) begin
            if (we_ram_i[n]) begin
                wmerge_c[8*n +: 8] = data_i[8*n +: 8];
            end
        end
    end

    // Read mux, sampled from pre-update register values.
    always_comb begin
        rdata_c = '0;
        case (off_c)
            OFF_CTRL:     rdata_c = {29'd0, ctrl_q};
            OFF_PRESCALE: rdata_c = {16'd0, prescale_q};
            OFF_COMPARE:  rdata_c = compare_q;
            OFF_COUNT:    rdata_c = count_q;
            OFF_STATUS:   rdata_c = {31'd0, match_q};
`ifdef BUS_TIMER_CAPTURE_EN
            OFF_CAPTURE:  rdata_c = capture_q;
`endif
            default:      rdata_c = '0;
        endcase
    end

    // Next-state for all registers.
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        match_d    = match_q;
        pcnt_d     = '0;
        data_d     = sel_c ? rdata_c : 32'd0;
`ifdef BUS_TIMER_CAPTURE_EN
        capture_d  = capture_q;
`endif

        if (ctrl_q[0] && !tick_c) begin
            pcnt_d = 16'(pcnt_q + 16'd1);
        end

        if (tick_c) begin
            count_d = (hit_c && ctrl_q[1]) ? 32'd0 : 32'(count_q + 32'd1);
        end

        if (wr_c) begin
            case (off_c)
                OFF_CTRL:     if (we_ram_i[0]) ctrl_d = data_i[2:0];
                OFF_PRESCALE: prescale_d = wmerge_c[15:0];
                OFF_COMPARE:  compare_d  = wmerge_c;
                OFF_COUNT:    count_d    = wmerge_c;
                OFF_STATUS:   if (we_ram_i[0] && data_i[0]) match_d = 1'b0;
`ifdef BUS_TIMER_CAPTURE_EN
                OFF_CAPTURE:  capture_d  = count_q;
`endif
                default:      ;
            endcase
        end

        // A match in the same cycle as a W1C wins.
        if (hit_c) begin
            match_d = 1'b1;
        end

        irq_d = match_d & ctrl_d[2];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            compare_q  <= '0;
            count_q    <= '0;
            match_q    <= 1'b0;
            pcnt_q     <= '0;
            data_q     <= '0;
            irq_q      <= 1'b0;
`ifdef BUS_TIMER_CAPTURE_EN
            capture_q  <= '0;
`endif
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            match_q    <= match_d;
            pcnt_q     <= pcnt_d;
            data_q     <= data_d;
            irq_q      <= irq_d;
`ifdef BUS_TIMER_CAPTURE_EN
            capture_q  <= capture_d;
`endif
        end
    end

    assign data_o = data_q;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// Testbench for bus_timer: directed scenarios plus randomized bus traffic,
// every cycle compared against a behavioural model of the register/timer rules.
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'h0000_9000;

    logic        clk_i;
    logic        reset_i;
    logic [31:0] address_i;
    logic [31:0] data_i;
    logic        we_i;
    logic [3:0]  we_ram_i;
    logic [31:0] data_o;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    bus_timer #(
        .BaseAddress   (BASE),
        .address_width (32)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .address_i (address_i),
        .data_i    (data_i),
        .we_i      (we_i),
        .we_ram_i  (we_ram_i),
        .data_o    (data_o),
        .irq_o     (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model state.
    logic [2:0]  m_ctrl;
    logic [15:0] m_pre;
    logic [31:0] m_cmp;
    logic [31:0] m_cnt;
    logic        m_match;
    logic [31:0] m_cap;
    int          m_phase;
    logic [31:0] m_data;
    logic        m_irq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) r[8*n +: 8] = d[8*n +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_pre = '0; m_cmp = '0; m_cnt = '0; m_match = 1'b0;
        m_cap = '0; m_phase = 0; m_data = '0; m_irq = 1'b0;
    endtask

    // One clock edge of the timer as described by its rules.
    task automatic model_step(input logic [31:0] a, input logic [31:0] d,
                              input logic w, input logic [3:0] be);
        bit          sel;
        int          off;
        bit          tick;
        bit          hit;
        logic [31:0] rd;
        logic [31:0] old_cnt;
        logic [31:0] t;
        sel = (a[31:5] == BASE[31:5]);
        off = int'(a[4:2]);
        case (off)
            0: rd = {29'd0, m_ctrl};
            1: rd = {16'd0, m_pre};
            2: rd = m_cmp;
            3: rd = m_cnt;
            4: rd = {31'd0, m_match};
`ifdef BUS_TIMER_CAPTURE_EN
            5: rd = m_cap;
`endif
            default: rd = 32'd0;
        endcase
        old_cnt = m_cnt;
        tick = m_ctrl[0] && (m_phase >= int'(m_pre));
        hit  = tick && (m_cnt == m_cmp);
        if (!m_ctrl[0] || tick) m_phase = 0;
        else m_phase = m_phase + 1;
        if (tick) m_cnt = (hit && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
        if (sel && w) begin
            case (off)
                0: if (be[0]) m_ctrl = d[2:0];
                1: begin t = lanes({16'd0, m_pre}, d, be); m_pre = t[15:0]; end
                2: m_cmp = lanes(m_cmp, d, be);
                3: m_cnt = lanes(old_cnt, d, be);
                4: if (be[0] && d[0]) m_match = 1'b0;
`ifdef BUS_TIMER_CAPTURE_EN
                5: m_cap = old_cnt;
`endif
                default: ;
            endcase
        end
        if (hit) m_match = 1'b1;
        m_data = sel ? rd : 32'd0;
        m_irq  = m_match & m_ctrl[2];
    endtask

    // Drive one bus cycle from a negedge, step the model at the edge, compare after it.
    task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d,
                             input logic w, input logic [3:0] be);
        address_i = a; data_i = d; we_i = w; we_ram_i = be;
        @(posedge clk_i);
        model_step(a, d, w, be);
        #1;
        check_eq("model_data_o", data_o, m_data);
        check_eq("model_irq_o", {31'd0, irq_o}, {31'd0, m_irq});
        @(negedge clk_i);
        address_i = '0; data_i = '0; we_i = 1'b0; we_ram_i = '0;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        bus_cycle(BASE + 32'(off * 4), d, 1'b1, 4'hF);
    endtask

    task automatic rd(input int off);
        bus_cycle(BASE + 32'(off * 4), 32'd0, 1'b0, 4'h0);
    endtask

    task automatic idle();
        bus_cycle(32'd0, 32'd0, 1'b0, 4'h0);
    endtask

    initial begin
        logic [31:0] exp_cap;
        reset_i = 1'b1; address_i = '0; data_i = '0; we_i = 1'b0; we_ram_i = '0;
        model_reset();
        #1;
        check_eq("reset_data_o", data_o, 32'd0);
        check_eq("reset_irq_o", {31'd0, irq_o}, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;

        // First access right after release, then compare-match timing with autoreload.
        wr(1, 32'd3);
        wr(2, 32'd2);
        rd(1);
        check_eq("prescale_rb", data_o, 32'd3);
        wr(0, 32'd7);
        for (int i = 1; i <= 11; i++) begin
            idle();
            check_eq("irq_before_match", {31'd0, irq_o}, 32'd0);
        end
        idle();
        check_eq("irq_at_match", {31'd0, irq_o}, 32'd1);
        rd(3);
        check_eq("count_reloaded", data_o, 32'd0);

        // W1C clears irq on the next cycle.
        wr(4, 32'd1);
        check_eq("irq_w1c", {31'd0, irq_o}, 32'd0);

        // W1C in the same cycle as a new match: MATCH holds.
        wr(0, 32'd0);
        wr(4, 32'd1);
        wr(3, 32'd10);
        wr(2, 32'd10);
        wr(1, 32'd0);
        wr(0, 32'd7);
        wr(4, 32'd1);
        check_eq("match_beats_w1c", {31'd0, irq_o}, 32'd1);
        rd(4);
        check_eq("status_set", data_o, 32'd1);

        // Counter wrap without match.
        wr(0, 32'd0);
        wr(4, 32'd1);
        wr(3, 32'hFFFF_FFFE);
        wr(2, 32'd5);
        wr(0, 32'd1);
        idle();
        idle();
        rd(3);
        check_eq("count_wrap", data_o, 32'd0);
        rd(4);
        check_eq("wrap_no_match", data_o, 32'd0);
        wr(0, 32'd0);

        // Byte-lane write and unselected access.
        wr(2, 32'd0);
        bus_cycle(BASE + 32'd8, 32'hAABB_CCDD, 1'b1, 4'b0010);
        rd(2);
        check_eq("compare_lane1", data_o, 32'h0000_CC00);
        bus_cycle(BASE + 32'h20, 32'd0, 1'b0, 4'h0);
        check_eq("unselected_zero", data_o, 32'd0);

        // Capture of a frozen counter.
        wr(3, 32'd100);
        bus_cycle(BASE + 32'd20, $urandom, 1'b1, 4'($urandom));
        rd(5);
`ifdef BUS_TIMER_CAPTURE_EN
        exp_cap = 32'd100;
`else
        exp_cap = 32'd0;
`endif
        check_eq("capture_read", data_o, exp_cap);

        // Asynchronous reset in the middle of a read with irq high.
        wr(3, 32'd7);
        wr(2, 32'd7);
        wr(0, 32'd7);
        idle();
        check_eq("irq_pre_reset", {31'd0, irq_o}, 32'd1);
        address_i = BASE + 32'd8;
        @(posedge clk_i);
        model_step(BASE + 32'd8, 32'd0, 1'b0, 4'h0);
        #1;
        check_eq("read_pre_reset", data_o, 32'd7);
        #2;
        reset_i = 1'b1;
        #1;
        check_eq("async_rst_data", data_o, 32'd0);
        check_eq("async_rst_irq", {31'd0, irq_o}, 32'd0);
        model_reset();
        @(negedge clk_i);
        address_i = '0;
        @(negedge clk_i);
        reset_i = 1'b0;
        idle();
        check_eq("post_reset_data", data_o, 32'd0);
        rd(3);
        check_eq("post_reset_count", data_o, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            int          kind;
            int          off;
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  be;
            kind = int'($urandom_range(0, 9));
            off  = int'($urandom_range(0, 7));
            if (kind == 0) a = 32'd0;
            else if (kind == 1) a = BASE + 32'h20 + 32'(off * 4);
            else a = BASE + 32'(off * 4);
            case (off)
                0: d = {$urandom_range(0, 1) == 0 ? 29'd0 : 29'($urandom), 3'($urandom) | 3'b001};
                1: d = $urandom_range(0, 4);
                2: d = $urandom_range(0, 12);
                3: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                     : $urandom_range(0, 12);
                default: d = $urandom;
            endcase
            be = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            bus_cycle(a, d, 1'($urandom_range(0, 1)), be);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameter BaseAddress, default 32'h0000_9000, byte address of register 0; SHALL be nonzero and 32-byte aligned.
REQ-002 Parameter address_width, default 32, width of address_i.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_i  input  1  reset, asynchronous, active-high.
REQ-005 address_i  input  address_width  bus address; nonzero only on the first cycle of a CPU access, 0 otherwise.
REQ-006 data_i  input  32  write data from the CPU.
REQ-007 we_i  input  1  write pulse, one cycle per write access.
REQ-008 we_ram_i  input  4  byte-lane write strobes; bit n enables data_i[8n+7:8n].
REQ-009 data_o  output  32  registered read data to the CPU.
REQ-010 irq_o  output  1  level interrupt request.

Function
REQ-011 Select SHALL be address_i[address_width-1:5] == BaseAddress[address_width-1:5]; offset = address_i[4:2].
REQ-012 Register map SHALL be:
- 0: CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; other bits read 0.
- 1: PRESCALE [15:0]; upper bits read 0.
- 2: COMPARE [31:0].
- 3: COUNT [31:0]; a write loads the counter.
- 4: STATUS: bit0 MATCH, write-1-to-clear.
- 5: CAPTURE [31:0], see REQ-027.
- 6-7: read 0, writes ignored.
REQ-013 A write SHALL occur when select && we_i; only lanes with we_ram_i[n]=1 SHALL be updated (STATUS: lane 0 bit0 W1C).
REQ-014 Read latency SHALL be exactly 1 cycle: the cycle after select, data_o = selected register value.
REQ-015 When not selected, data_o SHALL be 0 on the next cycle, so responders can be OR-combined.
REQ-016 Prescaler: with EN=1, the prescale counter SHALL count 0..PRESCALE and then return to 0, generating a tick on the PRESCALE cycle; one tick every PRESCALE+1 cycles (PRESCALE=0 gives a tick every cycle).
REQ-017 With EN=0, the prescale counter SHALL be held at 0 and COUNT frozen; setting EN SHALL restart the prescale from 0.
REQ-018 On a tick with COUNT==COMPARE, MATCH SHALL be set, and COUNT SHALL be 0 if AUTORELOAD=1, else COUNT+1.
REQ-019 On a tick with COUNT!=COMPARE, COUNT SHALL be COUNT+1, wrapping 32'hFFFF_FFFF to 0 without setting MATCH.
REQ-020 A CPU write to COUNT SHALL take priority over a same-cycle tick (written value, no increment); it SHALL not reset the prescaler.
REQ-021 A MATCH set and a W1C in the same cycle: MATCH SHALL remain 1.
REQ-022 A PRESCALE write below the current prescale count SHALL produce a tick on the next cycle, then the prescaler wraps to 0.
REQ-023 irq_o SHALL equal MATCH & IRQEN, driven directly from flops with no combinational path from bus inputs.

Reset
REQ-024 reset_i=1 SHALL asynchronously clear CTRL, PRESCALE, COMPARE, COUNT, STATUS, CAPTURE, the prescale counter and the data_o register to 0; irq_o SHALL be 0.
REQ-025 Reset asserted mid-access SHALL abort the access; data_o SHALL be 0 on the first edge after release.
REQ-026 The first access SHALL be accepted on the first rising edge with reset_i=0.

Configuration
REQ-027 With BUS_TIMER_CAPTURE_EN defined:
- any write to offset 5 SHALL load CAPTURE with the pre-update COUNT of that cycle, ignoring data_i and we_ram_i;
- reads of offset 5 SHALL return CAPTURE.
REQ-028 Without BUS_TIMER_CAPTURE_EN, CAPTURE SHALL not exist, offset 5 SHALL read 0, and writes to it SHALL be ignored.

Verification
REQ-029 Write PRESCALE=3, COMPARE=2, CTRL=3'b111 -> MATCH and irq_o rise 12 cycles after EN; COUNT reads 0 afterwards.
REQ-030 Write 1 to STATUS bit0 -> irq_o low next cycle; same-cycle tick match -> MATCH stays 1.
REQ-031 COUNT=32'hFFFF_FFFE, COMPARE=5, AUTORELOAD=0, PRESCALE=0, EN=1 -> COUNT reads 0 two ticks later, no MATCH.
REQ-032 Write we_ram_i=4'b0010, data_i=32'hAABBCCDD to COMPARE after writing 0 -> COMPARE reads 32'h0000CC00; access with address_i=BaseAddress+0x20 -> data_o=0 next cycle.
REQ-033 With EN=1, assert reset_i mid-count between clock edges -> all outputs 0 immediately, before the next edge.
REQ-034 With the macro, COUNT=100 frozen, write offset 5 -> CAPTURE reads 100; without the macro -> reads 0.
